axi_burst_master: RTL and testbench

- Single-outstanding AXI4 initiator (manager) that turns a simple command/stream interface into INCR bursts.
- Drives a full-width AXI slave such as the DDR simulation memory.
- Used by testbench traffic generators and, later, boot-loader DMA to preload and check DDR.
- Issues aligned, full-width, INCR bursts only, with one transaction in flight at a time.

---
 rtl/axi_burst_master.sv | 176 +++++++++++++++++
 tb/tb_axi_burst_master.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 initiator turning a command/stream interface into aligned INCR bursts.
// Build macro AXI_MST_BOUNDARY_CHK_EN: reject misaligned or 4 KiB-crossing commands at accept.
module axi_burst_master #(
    parameter int ADDR_WTH = 32,
    parameter int DATA_WTH = 256,
    parameter int ID_WIDTH = 4,
    parameter int MST_ID   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WTH-1:0]   cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [DATA_WTH-1:0]   wr_data,
    input  logic [DATA_WTH/8-1:0] wr_strb,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WTH-1:0]   rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  done_valid,
    output logic                  done_err,
    output logic [ADDR_WTH-1:0]   awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic [ID_WIDTH-1:0]   awid,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WTH-1:0]   wdata,
    output logic [DATA_WTH/8-1:0] wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic [ID_WIDTH-1:0]   bid,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_WTH-1:0]   araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [ID_WIDTH-1:0]   arid,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WTH-1:0]   rdata,
    input  logic [1:0]            rresp,
    input  logic [ID_WIDTH-1:0]   rid,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);
    localparam int BYTES = DATA_WTH / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam logic [ID_WIDTH-1:0] ID = ID_WIDTH'(MST_ID);

    typedef enum logic [2:0] {IDLE, AW, WD, BR, AR, RD, DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_WTH-1:0] addr_q;
    logic [7:0]          len_q;
    logic [7:0]          cnt;
    logic                err;
    logic                cmd_fire, w_fire, r_fire, last_beat, r_bad, cmd_reject;

`ifdef AXI_MST_BOUNDARY_CHK_EN
    logic [31:0] end_off;
    assign end_off    = 32'(cmd_addr[11:0]) + ((32'(cmd_len) + 32'd1) << SIZE);
    assign cmd_reject = (cmd_addr[SIZE-1:0] != '0) || (end_off > 32'd4096);
`else
    assign cmd_reject = 1'b0;
`endif

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign w_fire    = wvalid && wready;
    assign r_fire    = rvalid && rready;
    assign last_beat = (cnt == len_q);
    // rlast must coincide exactly with the final counted beat; either mismatch is an error
    assign r_bad     = (rresp != 2'b00) || (rid != ID) || (rlast != last_beat);

    assign awaddr  = addr_q;
    assign araddr  = addr_q;
    assign awlen   = len_q;
    assign arlen   = len_q;
    assign awsize  = 3'(SIZE);
    assign arsize  = 3'(SIZE);
    assign awburst = 2'b01;
    assign arburst = 2'b01;
    assign awid    = ID;
    assign arid    = ID;
    assign wdata   = wr_data;
    assign wstrb   = wr_strb;
    assign rd_data = rdata;
    assign done_err = (state == DONE) && err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            addr_q <= '0;
            len_q  <= '0;
            cnt    <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (cmd_fire) begin
                    addr_q <= cmd_addr;
                    len_q  <= cmd_len;
                    cnt    <= '0;
                    err    <= cmd_reject;
                end
                WD:   if (w_fire) cnt <= cnt + 8'd1;
                BR:   if (bvalid) err <= err || (bresp != 2'b00) || (bid != ID);
                RD:   if (r_fire) begin
                    cnt <= cnt + 8'd1;
                    err <= err || r_bad;
                end
                DONE: err <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        wr_ready   = 1'b0;
        wlast      = 1'b0;
        bready     = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        rd_valid   = 1'b0;
        rd_last    = 1'b0;
        done_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = cmd_reject ? DONE : (cmd_we ? AW : AR);
            end
            AW: begin
                awvalid = 1'b1;
                if (awready) state_nxt = WD;
            end
            WD: begin
                wvalid   = wr_valid;
                wr_ready = wready;
                wlast    = last_beat;
                if (wr_valid && wready && last_beat) state_nxt = BR;
            end
            BR: begin
                bready = 1'b1;
                if (bvalid) state_nxt = DONE;
            end
            AR: begin
                arvalid = 1'b1;
                if (arready) state_nxt = RD;
            end
            RD: begin
                rd_valid = rvalid;
                rready   = rd_ready;
                rd_last  = last_beat;
                if (rvalid && rd_ready && last_beat) state_nxt = DONE;
            end
            DONE: begin
                done_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_burst_master.sv
// Randomized bench for axi_burst_master: bench-side AXI slave memory plus a command-level reference memory.
`timescale 1ns/1ps
module tb_axi_burst_master;
    logic         clk = 1'b0;
    logic         rst_i;
    logic         cmd_valid, cmd_ready, cmd_we;
    logic [31:0]  cmd_addr;
    logic [7:0]   cmd_len;
    logic [255:0] wr_data;
    logic [31:0]  wr_strb;
    logic         wr_valid, wr_ready;
    logic [255:0] rd_data;
    logic         rd_last, rd_valid, rd_ready;
    logic         done_valid, done_err;
    logic [31:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst;
    logic [3:0]   awid, arid, bid, rid;
    logic         awvalid, awready, arvalid, arready;
    logic [255:0] wdata, rdata;
    logic [31:0]  wstrb;
    logic         wlast, wvalid, wready;
    logic [1:0]   bresp, rresp;
    logic         bvalid, bready, rlast, rvalid, rready;

    int checkCount = 0;
    int errorCount = 0;

    logic [255:0] slaveMem [longint];
    logic [255:0] modelMem [longint];

    always #5 clk = ~clk;

    axi_burst_master #(.ADDR_WTH(32), .DATA_WTH(256), .ID_WIDTH(4), .MST_ID(0)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done_valid(done_valid), .done_err(done_err),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awid(awid),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bid(bid), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [255:0] slaveGet(input longint k);
        return slaveMem.exists(k) ? slaveMem[k] : '0;
    endfunction

    function automatic logic [255:0] modelGet(input longint k);
        return modelMem.exists(k) ? modelMem[k] : '0;
    endfunction

    function automatic logic [255:0] mergeBytes(input logic [255:0] old, input logic [255:0] data,
                                                input logic [31:0] strb);
        logic [255:0] r;
        r = old;
        for (int b = 0; b < 32; b++)
            if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    // mode 0: always ready, 1: toggle every other cycle, 2: random
    function automatic logic pick(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return cyc[0];
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic idleInputs();
        cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_strb = '0; wr_valid = 0; rd_ready = 0;
        awready = 0; wready = 0; arready = 0;
        bresp = 0; bid = 0; bvalid = 0;
        rdata = '0; rresp = 0; rid = 0; rlast = 0; rvalid = 0;
    endtask

    // errKind: 0 clean, 1 bresp SLVERR, 2 bad bid, 3 bad rid, 4 rlast on beat 2, 5 rresp SLVERR
    task automatic applyStimulus(input bit we, input logic [31:0] addr, input int len, input int mode,
                                 input int errKind, input int abortAfter, input bit expReject);
        logic [255:0] beats[$];
        logic [31:0]  strbs[$];
        longint base, slvBase;
        int  wIdx, rIdx, sIdx, cyc, firstX, lastX, protoErr;
        bit  cmdPending, gotDone, awDone, arDone, bSent, awHeld, arHeld, awSeen, arSeen, expErr, usr;
        logic [39:0] heldAw, heldAr;
        base = longint'(addr >> 5);
        slvBase = 0;
        wIdx = 0; rIdx = 0; sIdx = 0; cyc = 0; firstX = -1; lastX = -1; protoErr = 0;
        cmdPending = 1; gotDone = 0; awDone = 0; arDone = 0; bSent = 0;
        awHeld = 0; arHeld = 0; awSeen = 0; arSeen = 0;
        heldAw = '0; heldAr = '0;
        for (int i = 0; i <= len; i++) begin
            beats.push_back({$urandom(), $urandom(), $urandom(), $urandom(),
                             $urandom(), $urandom(), $urandom(), $urandom()});
            strbs.push_back(mode == 2 ? $urandom() : 32'hFFFF_FFFF);
        end
        expErr = expReject || (we ? (errKind == 1 || errKind == 2) : (errKind >= 3));

        while (!gotDone && cyc < 2000) begin
            usr       = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            cmd_valid = cmdPending; cmd_we = we; cmd_addr = addr; cmd_len = 8'(len);
            awready   = pick(mode, cyc);
            arready   = pick(mode, cyc);
            wready    = pick(mode, cyc);
            wr_valid  = we && (wIdx <= len) && usr;
            if (wIdx <= len) begin
                wr_data = beats[wIdx]; wr_strb = strbs[wIdx];
            end else begin
                wr_data = '0; wr_strb = '0;
            end
            bvalid = we && awDone && (wIdx > len) && !bSent;
            bresp  = (errKind == 1) ? 2'b10 : 2'b00;
            bid    = (errKind == 2) ? 4'h5 : 4'h0;
            rvalid = !we && arDone && (sIdx <= len) && pick(mode, cyc);
            rdata  = slaveGet(slvBase + sIdx);
            rresp  = (errKind == 5 && sIdx == 0) ? 2'b10 : 2'b00;
            rid    = (errKind == 3 && sIdx == len) ? 4'h3 : 4'h0;
            rlast  = (errKind == 4) ? (sIdx == 1) : (sIdx == len);
            rd_ready = usr;
            #1;
            if (cyc == 0) checkOutput("cmd_ready_idle", cmd_ready, 1);
            if (int'(awvalid) + int'(wvalid) + int'(arvalid) > 1) protoErr++;
            if (awvalid) awSeen = 1;
            if (arvalid) arSeen = 1;
            if (awHeld && (!awvalid || {awaddr, awlen} !== heldAw)) protoErr++;
            if (arHeld && (!arvalid || {araddr, arlen} !== heldAr)) protoErr++;
            awHeld = 0; arHeld = 0;
            if (awvalid && awready) begin
                checkOutput("awaddr", awaddr, addr);
                checkOutput("awlen", awlen, len);
                checkOutput("awsize_burst_id", {awsize, awburst, awid}, {3'd5, 2'b01, 4'h0});
                awDone = 1;
                slvBase = longint'(awaddr >> 5);
            end else if (awvalid) begin
                awHeld = 1; heldAw = {awaddr, awlen};
            end
            if (arvalid && arready) begin
                checkOutput("araddr", araddr, addr);
                checkOutput("arlen", arlen, len);
                checkOutput("arsize_burst_id", {arsize, arburst, arid}, {3'd5, 2'b01, 4'h0});
                arDone = 1;
                slvBase = longint'(araddr >> 5);
            end else if (arvalid) begin
                arHeld = 1; heldAr = {araddr, arlen};
            end
            if (wvalid && (!awDone || wr_ready !== wready)) protoErr++;
            if (wvalid && wready) begin
                if (wIdx > len) protoErr++;
                else begin
                    checkOutput("wdata", wdata, beats[wIdx]);
                    checkOutput("wstrb", wstrb, strbs[wIdx]);
                    checkOutput("wlast", wlast, wIdx == len);
                    slaveMem[slvBase + wIdx] = mergeBytes(slaveGet(slvBase + wIdx), wdata, wstrb);
                end
                if (firstX < 0) firstX = cyc;
                lastX = cyc;
                wIdx++;
            end
            if (bvalid && bready) bSent = 1;
            if (rd_valid !== rvalid || (rvalid && rready !== rd_ready)) protoErr++;
            if (rvalid && rready) sIdx++;
            if (rd_valid && rd_ready) begin
                checkOutput("rd_data", rd_data, modelGet(base + rIdx));
                checkOutput("rd_last", rd_last, rIdx == len);
                if (firstX < 0) firstX = cyc;
                lastX = cyc;
                rIdx++;
            end
            if (done_valid) begin
                checkOutput("done_err", done_err, expErr);
                gotDone = 1;
            end
            if (cmdPending && cmd_ready) cmdPending = 0;
            if (abortAfter >= 0 && we && wIdx == abortAfter) begin
                @(posedge clk); @(negedge clk);
                rst_i = 1; wr_valid = 1; wready = 1;
                @(posedge clk); @(negedge clk);
                rst_i = 0;
                #1;
                checkOutput("abort_aw_w_valid", {awvalid, wvalid}, 2'b00);
                checkOutput("abort_cmd_ready", cmd_ready, 1);
                checkOutput("abort_done_valid", done_valid, 0);
                idleInputs();
                @(negedge clk);
                return;
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end

        if (!gotDone) checkOutput("timeout", 0, 1);
        checkOutput(we ? "w_beats" : "r_beats", we ? wIdx : rIdx, expReject ? 0 : len + 1);
        checkOutput("protocol", protoErr, 0);
        checkOutput("aw_ar_seen", {awSeen, arSeen}, {we && !expReject, !we && !expReject});
        if (mode == 0 && !expReject) checkOutput("no_bubble", lastX - firstX, len);
        if (we && gotDone && !expReject)
            for (int i = 0; i <= len; i++)
                modelMem[base + i] = mergeBytes(modelGet(base + i), beats[i], strbs[i]);
        idleInputs();
        #1;
        checkOutput("idle_after_done", {cmd_ready, done_valid}, 2'b10);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        int l, w, m;
        idleInputs();
        rst_i = 1;
        wr_valid = 1; rvalid = 1; wready = 1; awready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rd_valid, done_valid}, 7'b0);
        idleInputs();
        rst_i = 0;
        @(negedge clk);

        applyStimulus(1, 32'h8000_0000, 3, 0, 0, -1, 0);
        applyStimulus(0, 32'h8000_0000, 3, 0, 0, -1, 0);
        applyStimulus(1, 32'h8000_1000, 7, 1, 0, -1, 0);
        applyStimulus(0, 32'h8000_1000, 7, 1, 0, -1, 0);
        applyStimulus(1, 32'h8000_2000, 1, 0, 1, -1, 0);
        applyStimulus(0, 32'h8000_2000, 1, 0, 3, -1, 0);
        applyStimulus(0, 32'h8000_2000, 1, 0, 0, -1, 0);
        applyStimulus(1, 32'h8000_2400, 2, 2, 2, -1, 0);
        applyStimulus(0, 32'h8000_0000, 3, 0, 4, -1, 0);
        applyStimulus(0, 32'h8000_0000, 3, 2, 5, -1, 0);
        applyStimulus(1, 32'h8000_3000, 7, 0, 0, 1, 0);
        applyStimulus(1, 32'h8000_3000, 7, 0, 0, -1, 0);
        applyStimulus(0, 32'h8000_3000, 7, 2, 0, -1, 0);
        applyStimulus(1, 32'h8000_4000, 255, 0, 0, -1, 0);
        applyStimulus(0, 32'h8000_4000, 255, 2, 0, -1, 0);
`ifdef AXI_MST_BOUNDARY_CHK_EN
        applyStimulus(1, 32'h8000_0FE0, 1, 0, 0, -1, 1);
        applyStimulus(1, 32'h8000_0FC0, 1, 0, 0, -1, 0);
        applyStimulus(0, 32'h8000_0FC0, 1, 0, 0, -1, 0);
`endif
        for (int t = 0; t < 8; t++) begin
            l = $urandom_range(0, 15);
            w = $urandom_range(0, 127 - l);
            m = $urandom_range(0, 2);
            a = 32'h9000_0000 + 32'(t * 4096) + 32'(w * 32);
            applyStimulus(1, a, l, m, 0, -1, 0);
            applyStimulus(0, a, l, $urandom_range(0, 2), 0, -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
